// File: rtl/ovf_range_store.sv
// Circular store of recorded overflow intervals with a one-cycle registered range lookup.
// Optional build macro OVF_RANGE_MERGE_EN: coalesce writes that touch the newest interval.
module ovf_range_store #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [ADDR_W-1:0]          wr_first_i,
  input  logic [ADDR_W-1:0]          wr_last_i,
  input  logic                       lk_valid_i,
  input  logic [ADDR_W-1:0]          lk_addr_i,
  output logic                       lk_hit_o,
  output logic [$clog2(DEPTH)-1:0]   lk_idx_o,
  output logic [ADDR_W-1:0]          newest_first_o,
  output logic [ADDR_W-1:0]          newest_last_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       wrapped_o,
  output logic                       bad_wr_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] first_q [DEPTH];
  logic [ADDR_W-1:0] last_q  [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  newest_q;
  logic [IDX_W:0]    count_q;
  logic              wrapped_q;
  logic              bad_wr_q;
  logic              lk_hit_q;
  logic [IDX_W-1:0]  lk_idx_q;

  logic              wr_fire;
  logic              wr_bad;
  logic              wr_legal;
  logic              merge_hit;
  logic [ADDR_W-1:0] nw_first;
  logic [ADDR_W-1:0] nw_last;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;

  assign wr_ready_o = !rst_i && !clr_i;
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign wr_bad     = wr_first_i > wr_last_i;
  assign wr_legal   = wr_fire && !wr_bad;

  assign nw_first = first_q[newest_q];
  assign nw_last  = last_q[newest_q];

`ifdef OVF_RANGE_MERGE_EN
  // Extended by one bit so last+1 at the top of the address space cannot wrap to zero.
  logic [ADDR_W:0] nw_last_p1;
  logic [ADDR_W:0] wr_last_p1;
  assign nw_last_p1 = {1'b0, nw_last} + 1'b1;
  assign wr_last_p1 = {1'b0, wr_last_i} + 1'b1;
  assign merge_hit  = (count_q != '0) &&
                      ({1'b0, wr_first_i} <= nw_last_p1) &&
                      (wr_last_p1 >= {1'b0, nw_first});
`else
  assign merge_hit = 1'b0;
`endif

  // Scan downward so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (first_q[i] <= lk_addr_i) && (lk_addr_i <= last_q[i])) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      valid_q   <= '0;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      bad_wr_q  <= 1'b0;
      lk_hit_q  <= 1'b0;
      lk_idx_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
      end
    end else begin
      lk_hit_q <= lk_valid_i && hit_any;
      lk_idx_q <= lk_valid_i ? hit_idx : '0;
      if (wr_fire && wr_bad) begin
        bad_wr_q <= 1'b1;
      end else if (wr_legal && merge_hit) begin
        first_q[newest_q] <= (wr_first_i < nw_first) ? wr_first_i : nw_first;
        last_q[newest_q]  <= (wr_last_i > nw_last) ? wr_last_i : nw_last;
      end else if (wr_legal) begin
        first_q[wr_ptr_q] <= wr_first_i;
        last_q[wr_ptr_q]  <= wr_last_i;
        valid_q[wr_ptr_q] <= 1'b1;
        newest_q          <= wr_ptr_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        if (valid_q[wr_ptr_q]) wrapped_q <= 1'b1;
        if (count_q != (IDX_W+1)'(DEPTH)) count_q <= count_q + 1'b1;
      end
    end
  end

  assign lk_hit_o       = lk_hit_q;
  assign lk_idx_o       = lk_idx_q;
  assign count_o        = count_q;
  assign wrapped_o      = wrapped_q;
  assign bad_wr_o       = bad_wr_q;
  assign newest_first_o = (count_q == '0) ? '0 : nw_first;
  assign newest_last_o  = (count_q == '0) ? '0 : nw_last;

endmodule

// File: tb/tb_ovf_range_store.sv
// Vector-table bench for ovf_range_store; lookup results are checked through an expectation queue.
module tb_ovf_range_store;

`ifdef OVF_RANGE_MERGE_EN
  localparam int MERGE_CNT = 1;
  localparam logic [2:0] MERGE_IDX = 3'd0;
  localparam logic [31:0] MERGE_FIRST = 32'h3000;
`else
  localparam int MERGE_CNT = 2;
  localparam logic [2:0] MERGE_IDX = 3'd1;
  localparam logic [31:0] MERGE_FIRST = 32'h3040;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] wr_first_i = '0;
  logic [31:0] wr_last_i = '0;
  logic        lk_valid_i = 1'b0;
  logic [31:0] lk_addr_i = '0;
  logic        lk_hit_o;
  logic [2:0]  lk_idx_o;
  logic [31:0] newest_first_o;
  logic [31:0] newest_last_o;
  logic [3:0]  count_o;
  logic        wrapped_o;
  logic        bad_wr_o;

  always #5 clk_i = ~clk_i;

  ovf_range_store #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_first_i(wr_first_i), .wr_last_i(wr_last_i),
    .lk_valid_i(lk_valid_i), .lk_addr_i(lk_addr_i),
    .lk_hit_o(lk_hit_o), .lk_idx_o(lk_idx_o),
    .newest_first_o(newest_first_o), .newest_last_o(newest_last_o),
    .count_o(count_o), .wrapped_o(wrapped_o), .bad_wr_o(bad_wr_o)
  );

  typedef struct {
    logic        wv;
    logic [31:0] f;
    logic [31:0] l;
    logic        lv;
    logic [31:0] a;
    logic        clr;
    logic        rst;
    logic        eh;
    logic [2:0]  ei;
    int          ec;
    logic        ebad;
    logic        ewrap;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] lk_q[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic wv, logic [31:0] f, logic [31:0] l, logic lv,
                              logic [31:0] a, logic clr, logic rst, logic eh,
                              logic [2:0] ei, int ec, logic ebad, logic ewrap);
    vec_t v;
    v.wv = wv; v.f = f; v.l = l; v.lv = lv; v.a = a; v.clr = clr; v.rst = rst;
    v.eh = eh; v.ei = ei; v.ec = ec; v.ebad = ebad; v.ewrap = ewrap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int n);
    logic [3:0] e;
    @(negedge clk_i);
    wr_valid_i = v.wv; wr_first_i = v.f; wr_last_i = v.l;
    lk_valid_i = v.lv; lk_addr_i = v.a; clr_i = v.clr; rst_i = v.rst;
    lk_q.push_back({v.eh, v.ei});
    #1 chk($sformatf("v%0d wr_ready", n), 32'(wr_ready_o), 32'(!(v.rst || v.clr)));
    @(posedge clk_i);
    #1;
    wr_valid_i = 1'b0; lk_valid_i = 1'b0; clr_i = 1'b0; rst_i = 1'b0;
    e = lk_q.pop_front();
    chk($sformatf("v%0d lk_hit", n), 32'(lk_hit_o), 32'(e[3]));
    chk($sformatf("v%0d lk_idx", n), 32'(lk_idx_o), 32'(e[2:0]));
    chk($sformatf("v%0d count", n), 32'(count_o), 32'(v.ec));
    chk($sformatf("v%0d bad_wr", n), 32'(bad_wr_o), 32'(v.ebad));
    chk($sformatf("v%0d wrapped", n), 32'(wrapped_o), 32'(v.ewrap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // basic write, boundary lookups, same-cycle write/lookup, bad write, clear
    tbl.push_back(mk(1, 32'h1000, 32'h1020, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1020, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1021, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h2000, 32'h2010, 1, 32'h2005, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h2005, 0, 0, 1, 1, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1000, 0, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 32'h50, 32'h40, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1fff, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1000, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0));
    // nine disjoint intervals into eight entries
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(1, 32'(k) * 32'h100, 32'(k) * 32'h100 + 32'h40, 0, 0, 0, 0,
                       0, 0, (k < 8) ? k + 1 : 8, 0, k == 8));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0020, 0, 0, 0, 0, 8, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0820, 0, 0, 1, 0, 8, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0720, 0, 0, 1, 7, 8, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0140, 0, 0, 1, 1, 8, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0141, 0, 0, 0, 0, 8, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], i);
      if (i == 0) begin
        chk("reset newest_first", newest_first_o, 32'h0);
        chk("reset newest_last", newest_last_o, 32'h0);
      end
    end
    chk("wrap newest_first", newest_first_o, 32'h800);
    chk("wrap newest_last", newest_last_o, 32'h840);

    // adjacent intervals: coalesced only when the merge build is enabled
    run(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 100);
    run(mk(1, 32'h3000, 32'h303f, 0, 0, 0, 0, 0, 0, 1, 0, 0), 101);
    run(mk(1, 32'h3040, 32'h307f, 0, 0, 0, 0, 0, 0, MERGE_CNT, 0, 0), 102);
    chk("merge newest_first", newest_first_o, MERGE_FIRST);
    chk("merge newest_last", newest_last_o, 32'h307f);
    run(mk(0, 0, 0, 1, 32'h3050, 0, 0, 1, MERGE_IDX, MERGE_CNT, 0, 0), 103);

    // reset in the middle of back-to-back traffic
    run(mk(1, 32'h9000, 32'h9010, 1, 32'h3000, 0, 0, 1, 0, MERGE_CNT + 1, 0, 0), 200);
    run(mk(1, 32'ha000, 32'ha010, 1, 32'h3000, 0, 1, 0, 0, 0, 0, 0), 201);
    chk("midrst newest_first", newest_first_o, 32'h0);
    chk("midrst newest_last", newest_last_o, 32'h0);
    run(mk(0, 0, 0, 1, 32'h9005, 0, 0, 0, 0, 0, 0, 0), 202);

    // clear beats a same-cycle write
    run(mk(1, 32'h100, 32'h200, 0, 0, 1, 0, 0, 0, 0, 0, 0), 300);
    run(mk(0, 0, 0, 1, 32'h150, 0, 0, 0, 0, 0, 0, 0), 301);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
